captura_operandos: RTL and testbench
====================================

// Module: captura_operandos
// PURPOSE
//   Producer end of the operand handshake into the Booth multiplier (calculo_multiplicacion).
//   Synchronizes and debounces the two 8-bit switch banks.
//   Latches a stable operand pair and offers it on A/B with valid.
//   Holds the pair until the multiplier accepts it with ready, then offers the next change.
// PARAMETERS
//   WIDTH     8       operand width, per bank
//   DB_COUNT  100000  consecutive unchanged cycles needed to accept a switch value (>=2)
//   CNT_W     17      debounce counter width; must satisfy 2**CNT_W > DB_COUNT
// PORTS
//   clk       in   1      system clock; all logic on rising edge
//   rst_n     in   1      synchronous reset, active-low
//   switch_A  in   WIDTH  raw switch bank A (asynchronous, bouncy)
//   switch_B  in   WIDTH  raw switch bank B (asynchronous, bouncy)
//   ready     in   1      multiplier can accept an operand pair this cycle
//   A         out  WIDTH  offered multiplicand, registered
//   B         out  WIDTH  offered multiplier, registered
//   valid     out  1      A/B hold a pair not yet accepted
//   overrun   out  1      only with CAPTURA_OVERRUN_EN; see CONFIGURATION
// BEHAVIOUR
// - Reset (rst_n=0 at an edge) clears:
//   - A=0, B=0, valid=0, overrun=0
//   - sync flops, stable register, last_sent register and debounce counter
//   - FSM goes to IDLE
//   - Reset mid-OFFER drops the pending pair; no transfer is counted.
// - Synchronizer: 2-flop synchronizer on all 2*WIDTH bits; s = {switch_A,switch_B} after sync.
// - Debounce (one counter shared by the full 2*WIDTH vector):
//   - s != s_prev: counter <= 0.
//   - Otherwise the counter increments, saturating at DB_COUNT.
//   - When the counter reaches DB_COUNT-1 with s unchanged: stable <= s.
//   - Any bounce on any bit restarts the window.
// - FSM, 2 states:
//   - IDLE:
//     - If stable != last_sent: A/B <= stable halves, last_sent <= stable, valid <= 1, go to OFFER.
//     - Otherwise stay in IDLE, valid=0.
//   - OFFER:
//     - valid=1; A/B frozen even if stable changes.
//     - Transfer completes at the edge where valid&&ready=1.
//     - At that edge: valid <= 0, go to IDLE. One pair per transfer; no back-to-back in the same cycle.
// - Handshake rules:
//   - valid never drops without a transfer.
//   - A/B never change while valid=1.
//   - ready is ignored in IDLE.
//   - ready may be held high permanently; each pair then transfers 1 cycle after valid rises.
// - Latency:
//   - From a clean switch change to valid rising: between DB_COUNT+2 and DB_COUNT+4 cycles, inclusive.
//   - After a transfer, a pending change is offered 1 cycle later (back through IDLE).
// - Boundaries:
//   - All-zero switches after reset: stable == last_sent == 0, so no offer.
//   - Switches changed then restored before DB_COUNT elapses: no offer.
//   - Multiple stable changes during OFFER: only the latest stable value is offered next; intermediate values are lost.
//   - Value returns to last_sent during OFFER: nothing further is offered.
// CONFIGURATION
//   `CAPTURA_OVERRUN_EN` defined:
//   - Output overrun exists.
//   - overrun is sticky-set when stable updates to a new value while in OFFER, and is lost before transfer.
//   - Precisely: overrun sets if a second stable update occurs during a single OFFER, or any update differs from the offered pair.
//   - Cleared only by reset.
//   Not defined:
//   - Port overrun is absent and no overrun logic is built.
//   - All other behaviour is identical.
// TESTING (bench DB_COUNT=4)
// 1. Reset 3 cycles, switches 0 -> A=0, B=0, valid=0, no valid for 50 cycles.
// 2. switch_A=8'h07, switch_B=8'hFD, ready=1 -> valid rises in cycles 6..8, A=07, B=FD, one-cycle pulse.
// 3. Bounce switch_A 0x05<->0x06 every 2 cycles for 20 cycles, then hold 0x06 -> exactly one offer, A=06.
// 4. ready=0, offer A=12, B=34; change switches to 55/66 -> A/B stay 12/34, valid held.
//    Then raise ready -> transfer; 55/66 offered 1 cycle later.
// 5. rst_n=0 while valid=1 -> next cycle valid=0, A=0, B=0.
//    Re-offer of the current switches follows DB_COUNT+2..4 cycles after release.
// 6. CAPTURA_OVERRUN_EN, ready=0, offer 01/01; switches -> 02/02, then 03/03 -> overrun=1.
//    overrun persists after transfer; cleared only by rst_n.

Source files
------------

// File: rtl/captura_operandos.sv
// captura_operandos
//   Producer end of the operand handshake into the Booth multiplier.
//   Both 8-bit switch banks go through a 2-flop synchronizer and a shared
//   debounce window. A stable operand pair that differs from the last pair
//   sent is latched onto A/B and offered with valid. It is held until the
//   consumer accepts it with ready.
//
// Optional feature macro: CAPTURA_OVERRUN_EN
//   When defined, an 'overrun' output flags stable switch updates that were
//   lost while a pair sat unaccepted in OFFER. The flag is sticky until reset.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      synchronous reset, active-low
//   switch_A  in   WIDTH  raw switch bank A (asynchronous, bouncy)
//   switch_B  in   WIDTH  raw switch bank B (asynchronous, bouncy)
//   ready     in   1      consumer accepts the offered pair this cycle
//   A         out  WIDTH  offered multiplicand, registered
//   B         out  WIDTH  offered multiplier, registered
//   valid     out  1      A/B hold a pair not yet accepted
//   overrun   out  1      CAPTURA_OVERRUN_EN only: sticky lost-update flag
module captura_operandos #(
    parameter int WIDTH    = 8,
    parameter int DB_COUNT = 100000,
    parameter int CNT_W    = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch_A,
    input  logic [WIDTH-1:0] switch_B,
    input  logic             ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             valid
`ifdef CAPTURA_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    localparam int unsigned SW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_COUNT);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t state, state_next;

    logic [SW-1:0]    sync1;
    logic [SW-1:0]    s;
    logic [SW-1:0]    s_prev;
    logic [SW-1:0]    stable;
    logic [SW-1:0]    last_sent;
    logic [CNT_W-1:0] cnt;
    logic             stable_load;
    logic             offer_load;

    // The window closes on the cycle the counter reaches DB_COUNT-1 with s
    // still unchanged. Saturation keeps it from reloading afterwards.
    assign stable_load = (s == s_prev) && (cnt == DB_LAST);

    // Synchronizer and debounce.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= '0;
            s      <= '0;
            s_prev <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1  <= {switch_A, switch_B};
            s      <= sync1;
            s_prev <= s;
            if (s != s_prev) begin
                cnt <= '0;
            end else if (cnt != DB_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (stable_load) begin
                stable <= s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        offer_load = 1'b0;
        case (state)
            IDLE: begin
                if (stable != last_sent) begin
                    offer_load = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Offered pair and valid. A/B only load on the IDLE->OFFER step, so they
    // stay frozen for the whole OFFER.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            A         <= '0;
            B         <= '0;
            valid     <= 1'b0;
            last_sent <= '0;
        end else begin
            valid <= (state_next == OFFER);
            if (offer_load) begin
                {A, B}    <= stable;
                last_sent <= stable;
            end
        end
    end

`ifdef CAPTURA_OVERRUN_EN
    logic upd_seen;

    // A stable update during OFFER is lost if it differs from the pair on
    // offer, or if it is the second update in the same OFFER. An update on the
    // accepting edge is not lost, because IDLE picks it up next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            upd_seen <= 1'b0;
        end else if (offer_load) begin
            upd_seen <= 1'b0;
        end else if (state == OFFER && !ready && stable_load) begin
            upd_seen <= 1'b1;
            if (upd_seen || (s != {A, B})) begin
                overrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_captura_operandos.sv
module tb_captura_operandos;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] switch_A = '0;
    logic [7:0] switch_B = '0;
    logic       ready = 1'b0;
    logic [7:0] A;
    logic [7:0] B;
    logic       valid;
`ifdef CAPTURA_OVERRUN_EN
    logic       overrun;
`endif

    captura_operandos #(
        .WIDTH   (8),
        .DB_COUNT(4),
        .CNT_W   (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .switch_A(switch_A),
        .switch_B(switch_B),
        .ready   (ready),
        .A       (A),
        .B       (B),
        .valid   (valid)
`ifdef CAPTURA_OVERRUN_EN
        ,
        .overrun (overrun)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Expected pairs in offer order. model_last is the last pair the
    // reference expects the producer to have sent.
    logic [15:0] exp_q[$];
    logic [15:0] model_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sw(input logic [15:0] v);
        {switch_A, switch_B} = v;
    endtask

    // A held, debounced value is offered exactly when it differs from the last pair sent.
    task automatic expect_pair(input logic [15:0] v);
        if (v != model_last) begin
            exp_q.push_back(v);
            model_last = v;
        end
    endtask

    task automatic wait_valid(input string name, input int lo, input int hi);
        int n = 0;
        while (!valid && n < hi + 5) begin
            cyc(1);
            n++;
        end
        check({name, "_latency"}, {31'd0, (valid && n >= lo && n <= hi)}, 32'd1);
    endtask

    // Monitor: pops the scoreboard on each transfer and checks hold rules.
    logic        pv = 1'b0;
    logic        px = 1'b0;
    logic [15:0] pab = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            px = 1'b0;
        end else begin
            if (pv && !px) begin
                check("hold_valid", {31'd0, valid}, 32'd1);
                check("hold_AB", {16'd0, A, B}, {16'd0, pab});
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_offer: actual=%h required=none", {A, B});
                end else begin
                    check("transfer_AB", {16'd0, A, B}, {16'd0, exp_q.pop_front()});
                end
            end
            pv  = valid;
            px  = valid && ready;
            pab = {A, B};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        logic [15:0] v;

        // 1: reset and idle with all-zero switches
        rst_n = 1'b0;
        cyc(3);
        check("reset_A", {24'd0, A}, 32'd0);
        check("reset_B", {24'd0, B}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        rst_n = 1'b1;
        vc = 0;
        repeat (50) begin
            cyc(1);
            if (valid) vc++;
        end
        check("idle_no_offer", vc, 0);

        // 2: clean change, ready held high
        ready = 1'b1;
        set_sw(16'h07FD);
        expect_pair(16'h07FD);
        wait_valid("t2", 6, 8);
        check("t2_A", {24'd0, A}, 32'h07);
        check("t2_B", {24'd0, B}, 32'hFD);
        cyc(1);
        check("t2_pulse", {31'd0, valid}, 32'd0);

        // 3: bounce on bank A, then hold
        for (int i = 0; i < 10; i++) begin
            switch_A = (i % 2 == 1) ? 8'h06 : 8'h05;
            cyc(2);
        end
        expect_pair(16'h06FD);
        cyc(20);
        check("t3_one_offer", exp_q.size(), 0);

        // 4: pair frozen while ready is low, newer value offered after transfer
        ready = 1'b0;
        set_sw(16'h1234);
        expect_pair(16'h1234);
        wait_valid("t4_offer", 0, 12);
        check("t4_AB", {16'd0, A, B}, 32'h1234);
        set_sw(16'h5566);
        expect_pair(16'h5566);
        cyc(15);
        check("t4_frozen_AB", {16'd0, A, B}, 32'h1234);
        check("t4_valid_held", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        cyc(1);
        check("t4_idle_gap", {31'd0, valid}, 32'd0);
        cyc(1);
        check("t4_next_valid", {31'd0, valid}, 32'd1);
        check("t4_next_AB", {16'd0, A, B}, 32'h5566);
        cyc(1);

        // 5: reset mid-offer drops the pair, then it is re-offered
        ready = 1'b0;
        set_sw(16'h7788);
        expect_pair(16'h7788);
        wait_valid("t5_offer", 0, 12);
        rst_n = 1'b0;
        cyc(1);
        check("t5_rst_valid", {31'd0, valid}, 32'd0);
        check("t5_rst_AB", {16'd0, A, B}, 32'd0);
        void'(exp_q.pop_back());
        model_last = '0;
        rst_n = 1'b1;
        expect_pair(16'h7788);
        wait_valid("t5_reoffer", 6, 8);
        ready = 1'b1;
        cyc(2);

        // randomized: glitch bursts, then a held value
        for (int it = 0; it < 15; it++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                set_sw(16'($urandom));
                ready = 1'($urandom_range(0, 1));
                cyc($urandom_range(1, 2));
            end
            v = ($urandom_range(0, 3) == 0) ? model_last : 16'($urandom);
            set_sw(v);
            expect_pair(v);
            repeat (40) begin
                ready = 1'($urandom_range(0, 1));
                cyc(1);
            end
            ready = 1'b1;
            cyc(3);
            check("rand_drained", {31'd0, valid}, 32'd0);
        end

`ifdef CAPTURA_OVERRUN_EN
        // 6: lost updates during OFFER set a sticky overrun
        rst_n = 1'b0;
        ready = 1'b0;
        set_sw(16'h0000);
        cyc(2);
        model_last = '0;
        check("t6_ovr_reset", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        set_sw(16'h0101);
        expect_pair(16'h0101);
        wait_valid("t6_offer", 0, 12);
        set_sw(16'h0202);
        cyc(12);
        set_sw(16'h0303);
        cyc(12);
        check("t6_overrun", {31'd0, overrun}, 32'd1);
        check("t6_frozen_AB", {16'd0, A, B}, 32'h0101);
        expect_pair(16'h0303);
        ready = 1'b1;
        cyc(3);
        check("t6_ovr_sticky", {31'd0, overrun}, 32'd1);
        rst_n = 1'b0;
        set_sw(16'h0000);
        cyc(1);
        check("t6_ovr_clear", {31'd0, overrun}, 32'd0);
        model_last = '0;
        rst_n = 1'b1;
        ready = 1'b0;
`endif

        cyc(20);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
